// File: rtl/gcd_client_if.sv
// gcd_client_if: groups the three val/rdy channels around the GCD client.
//   src  : test source -> client   {a, b, expected}
//   req  : client -> GCD unit      {a, b}
//   resp : GCD unit -> client      result
// master = the client side, slave = the environment (source + GCD unit).
interface gcd_client_if #(
    parameter int NBITS = 16
);
    logic               src_val;
    logic               src_rdy;
    logic [3*NBITS-1:0] src_msg;

    logic               req_val;
    logic               req_rdy;
    logic [2*NBITS-1:0] req_msg;

    logic               resp_val;
    logic               resp_rdy;
    logic [NBITS-1:0]   resp_msg;

    modport master (
        input  src_val, src_msg, req_rdy, resp_val, resp_msg,
        output src_rdy, req_val, req_msg, resp_rdy
    );

    modport slave (
        output src_val, src_msg, req_rdy, resp_val, resp_msg,
        input  src_rdy, req_val, req_msg, resp_rdy
    );
endinterface

// File: rtl/gcd_client.sv
// gcd_client: initiator/checker in front of a GCD unit.
// Takes {a, b, expected} from a source, issues {a, b} through a one-entry
// request register, keeps expected values in an in-order FIFO and scores
// each returned result against the FIFO head (saturating sent/pass/fail
// counters, sticky err).
// Optional: define GCD_CLIENT_TIMEOUT_EN to add a response watchdog and a
// sticky 'timeout' output port.
module gcd_client #(
    parameter int NBITS          = 16,
    parameter int MAX_INFLIGHT   = 4,
    parameter int CNT_NBITS      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gcd_client_if.master         bus,
    output logic [CNT_NBITS-1:0] num_sent,
    output logic [CNT_NBITS-1:0] num_pass,
    output logic [CNT_NBITS-1:0] num_fail,
    output logic                 err,
    output logic                 idle
`ifdef GCD_CLIENT_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);
    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = AW + 1;
    localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;

    // request register
    logic               req_val_q;
    logic [2*NBITS-1:0] req_msg_q;

    // expected FIFO
    logic [NBITS-1:0]   exp_mem [MAX_INFLIGHT];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               fifo_full;
    logic               fifo_empty;

    // requests issued to the GCD unit but not yet answered
    logic [CW-1:0]      outst;

    logic               src_fire;
    logic               req_fire;
    logic               resp_fire;
    logic               resp_match;
    logic               err_set;

    assign fifo_full  = (count == CW'(MAX_INFLIGHT));
    assign fifo_empty = (count == '0);

    // Accept a new transaction only if the request register frees up this
    // cycle and the FIFO has room; full blocks push even alongside a pop.
    assign bus.src_rdy  = reset_n && (!req_val_q || bus.req_rdy) && !fifo_full;
    // A result is only meaningful once its request has actually gone out.
    assign bus.resp_rdy = !fifo_empty && (outst != '0);
    assign bus.req_val  = req_val_q;
    assign bus.req_msg  = req_msg_q;

    assign src_fire   = bus.src_val && bus.src_rdy;
    assign req_fire   = req_val_q && bus.req_rdy;
    assign resp_fire  = bus.resp_val && bus.resp_rdy;
    assign resp_match = (bus.resp_msg == exp_mem[rd_ptr]);

    assign idle = !req_val_q && fifo_empty;

    // Request register: load on src fire (also reloads on a same-cycle
    // req fire), hold while stalled, clear after issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_val_q <= 1'b0;
            req_msg_q <= '0;
        end else if (src_fire) begin
            req_val_q <= 1'b1;
            req_msg_q <= bus.src_msg[3*NBITS-1:NBITS];
        end else if (req_fire) begin
            req_val_q <= 1'b0;
        end
    end

    // Expected-value storage; contents are qualified by count, no reset needed.
    always_ff @(posedge clk) begin
        if (src_fire) exp_mem[wr_ptr] <= bus.src_msg[NBITS-1:0];
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (src_fire)  wr_ptr <= wr_ptr + AW'(1);
            if (resp_fire) rd_ptr <= rd_ptr + AW'(1);
            unique case ({src_fire, resp_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Issued-outstanding count: 0 means WAIT, >0 means EXPECT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outst <= '0;
        end else begin
            unique case ({req_fire, resp_fire})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: ;
            endcase
        end
    end

`ifdef GCD_CLIENT_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_cnt;
    logic           wd_hit;

    // Fires on the cycle the watchdog steps onto its limit.
    assign wd_hit  = (outst != '0) && !resp_fire && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign err_set = (resp_fire && !resp_match) || wd_hit;

    // Watchdog: count stalled EXPECT cycles, hold at the limit, flag sticky timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (outst == '0 || resp_fire)
                wd_cnt <= '0;
            else if (wd_cnt != WDW'(TIMEOUT_CYCLES))
                wd_cnt <= wd_cnt + WDW'(1);
            if (wd_hit) timeout <= 1'b1;
        end
    end
`else
    assign err_set = resp_fire && !resp_match;
`endif

    // Saturating status counters and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_sent <= '0;
            num_pass <= '0;
            num_fail <= '0;
            err      <= 1'b0;
        end else begin
            if (req_fire && num_sent != CNT_MAX) num_sent <= num_sent + CNT_NBITS'(1);
            if (resp_fire) begin
                if (resp_match) begin
                    if (num_pass != CNT_MAX) num_pass <= num_pass + CNT_NBITS'(1);
                end else begin
                    if (num_fail != CNT_MAX) num_fail <= num_fail + CNT_NBITS'(1);
                end
            end
            if (err_set) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed scenarios plus a randomized run in which the bench
// plays both the test source and a GCD unit; a queue-based reference model
// predicts handshakes, request contents and status counters.
// Counters are built 3 bits wide so saturation is reached in the random run.
module tb_gcd_client;
    localparam int N  = 16;
    localparam int CW = 3;
    localparam int CMAX = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [CW-1:0] num_sent, num_pass, num_fail;
    logic err, idle;
`ifdef GCD_CLIENT_TIMEOUT_EN
    logic timeout;
`endif

    int vectors = 0;
    int miscompares = 0;

    gcd_client_if #(.NBITS(N)) bus ();

    gcd_client #(.NBITS(N), .MAX_INFLIGHT(4), .CNT_NBITS(CW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .num_sent(num_sent), .num_pass(num_pass), .num_fail(num_fail),
        .err(err), .idle(idle)
`ifdef GCD_CLIENT_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] gcd16(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] a, b, t;
        a = x; b = y;
        while (b != 0) begin t = a % b; a = b; b = t; end
        return a;
    endfunction

    task automatic tick;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset;
        bus.src_val = 0; bus.src_msg = '0; bus.req_rdy = 0;
        bus.resp_val = 0; bus.resp_msg = '0;
        reset_n = 0; tick; tick; reset_n = 1;
    endtask

    // Offer one source transaction until accepted (bounded).
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        bit ok;
        ok = 0;
        bus.src_val = 1; bus.src_msg = {a, b, e};
        for (int i = 0; i < 50 && !ok; i++) begin
            #1; if (bus.src_rdy) ok = 1;
            tick;
        end
        bus.src_val = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL send_accept got no src_rdy, want src_rdy=1 within 50 cycles"); end
    endtask

    // Present one result until accepted (bounded).
    task automatic respond(input logic [15:0] r);
        bit ok;
        ok = 0;
        bus.resp_val = 1; bus.resp_msg = r;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1; if (bus.resp_rdy) ok = 1;
            tick;
        end
        bus.resp_val = 0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL resp_accept got no resp_rdy, want resp_rdy=1 within 50 cycles"); end
    endtask

    task automatic test_reset;
        bus.src_val = 1; bus.req_rdy = 1; bus.resp_val = 1;
        #1;
        vectors++;
        if ({bus.req_val, bus.req_msg, bus.src_rdy, bus.resp_rdy, num_sent, num_pass, num_fail, err, idle}
            !== {1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state got val=%b msg=%h srdy=%b rrdy=%b s/p/f=%0d/%0d/%0d err=%b idle=%b, want 0 0 0 0 0/0/0 0 1",
                     bus.req_val, bus.req_msg, bus.src_rdy, bus.resp_rdy, num_sent, num_pass, num_fail, err, idle);
        end
        do_reset;
    endtask

    task automatic test_single_pass;
        do_reset;
        bus.req_rdy = 1;
        send(16'h000f, 16'h0005, 16'h0005);
        vectors++;
        if ({bus.req_val, bus.req_msg} !== {1'b1, 32'h000f0005}) begin
            miscompares++; $display("FAIL single_req got val=%b msg=%h want 1 000f0005", bus.req_val, bus.req_msg);
        end
        tick; tick; tick;
        respond(16'h0005);
        vectors++;
        if ({num_sent, num_pass, num_fail, err, idle} !== {3'd1, 3'd1, 3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL single_status got s/p/f=%0d/%0d/%0d err=%b idle=%b want 1/1/0 0 1", num_sent, num_pass, num_fail, err, idle);
        end
    endtask

    task automatic test_mismatch;
        do_reset;
        bus.req_rdy = 1;
        send(16'h0006, 16'h0004, 16'h0003);
        respond(16'h0002);
        vectors++;
        if ({num_fail, num_pass, err} !== {3'd1, 3'd0, 1'b1}) begin
            miscompares++; $display("FAIL mismatch_flag got fail=%0d pass=%0d err=%b want 1 0 1", num_fail, num_pass, err);
        end
        send(16'h000f, 16'h0005, 16'h0005);
        respond(16'h0005);
        vectors++;
        if ({num_fail, num_pass, err} !== {3'd1, 3'd1, 1'b1}) begin
            miscompares++; $display("FAIL mismatch_sticky got fail=%0d pass=%0d err=%b want 1 1 1", num_fail, num_pass, err);
        end
    endtask

    task automatic test_full_fifo;
        do_reset;
        bus.req_rdy = 1; bus.src_val = 1;
        for (int i = 0; i < 4; i++) begin
            bus.src_msg = {16'(i + 2), 16'(i + 2), 16'(i + 2)};
            #1;
            vectors++;
            if (bus.src_rdy !== 1'b1) begin miscompares++; $display("FAIL full_accept%0d got src_rdy=%b want 1", i, bus.src_rdy); end
            tick;
        end
        bus.src_msg = {16'h0009, 16'h0003, 16'h0003};
        #1;
        vectors++;
        if (bus.src_rdy !== 1'b0) begin miscompares++; $display("FAIL full_block got src_rdy=%b want 0", bus.src_rdy); end
        tick;
        bus.resp_val = 1; bus.resp_msg = 16'h0002;
        #1;
        vectors++;
        if ({bus.src_rdy, bus.resp_rdy} !== 2'b01) begin
            miscompares++; $display("FAIL full_popcycle got src_rdy=%b resp_rdy=%b want 0 1", bus.src_rdy, bus.resp_rdy);
        end
        tick;
        bus.resp_val = 0;
        #1;
        vectors++;
        if (bus.src_rdy !== 1'b1) begin miscompares++; $display("FAIL full_fifth got src_rdy=%b want 1", bus.src_rdy); end
        tick;
        bus.src_val = 0;
        tick;
        vectors++;
        if ({num_sent, num_pass} !== {3'd5, 3'd1}) begin
            miscompares++; $display("FAIL full_counts got sent=%0d pass=%0d want 5 1", num_sent, num_pass);
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        send(16'h0030, 16'h0012, 16'h0006);
        bus.src_val = 1; bus.src_msg = {16'h0015, 16'h000e, 16'h0007};
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({bus.src_rdy, bus.req_val, bus.req_msg, num_sent} !== {1'b0, 1'b1, 32'h00300012, 3'd0}) begin
                miscompares++;
                $display("FAIL bp_hold%0d got srdy=%b val=%b msg=%h sent=%0d want 0 1 00300012 0",
                         i, bus.src_rdy, bus.req_val, bus.req_msg, num_sent);
            end
            tick;
        end
        bus.req_rdy = 1;
        #1;
        vectors++;
        if (bus.src_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_release got src_rdy=%b want 1", bus.src_rdy); end
        tick;
        bus.src_val = 0;
        vectors++;
        if ({num_sent, bus.req_val, bus.req_msg} !== {3'd1, 1'b1, 32'h0015000e}) begin
            miscompares++; $display("FAIL bp_reload got sent=%0d val=%b msg=%h want 1 1 0015000e", num_sent, bus.req_val, bus.req_msg);
        end
    endtask

    task automatic test_streaming;
        do_reset;
        bus.req_rdy = 1;
        send(16'h0007, 16'h0003, 16'h0001);
        send(16'h0009, 16'h0006, 16'h0003);
        tick;
        bus.src_val = 1; bus.src_msg = {16'h000e, 16'h0007, 16'h0007};
        bus.resp_val = 1; bus.resp_msg = 16'h0001;
        #1;
        vectors++;
        if ({bus.src_rdy, bus.resp_rdy} !== 2'b11) begin
            miscompares++; $display("FAIL stream_both got src_rdy=%b resp_rdy=%b want 1 1", bus.src_rdy, bus.resp_rdy);
        end
        tick;
        bus.src_val = 0; bus.resp_val = 0;
        respond(16'h0003);
        vectors++;
        if ({idle, num_pass} !== {1'b0, 3'd2}) begin
            miscompares++; $display("FAIL stream_mid got idle=%b pass=%0d want 0 2", idle, num_pass);
        end
        respond(16'h0007);
        vectors++;
        if ({num_pass, num_fail, err, idle} !== {3'd3, 3'd0, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL stream_end got pass=%0d fail=%0d err=%b idle=%b want 3 0 0 1", num_pass, num_fail, err, idle);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        bus.req_rdy = 1;
        send(16'h0006, 16'h0004, 16'h0003);
        respond(16'h0002);
        send(16'h0004, 16'h0002, 16'h0002);
        send(16'h0006, 16'h0003, 16'h0003);
        send(16'h0008, 16'h0004, 16'h0004);
        #2;
        reset_n = 0;
        #1;
        vectors++;
        if ({bus.req_val, num_sent, num_pass, num_fail, err, idle, bus.src_rdy, bus.resp_rdy}
            !== {1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset got val=%b s/p/f=%0d/%0d/%0d err=%b idle=%b srdy=%b rrdy=%b want 0 0/0/0 0 1 0 0",
                     bus.req_val, num_sent, num_pass, num_fail, err, idle, bus.src_rdy, bus.resp_rdy);
        end
        @(negedge clk);
        do_reset;
    endtask

`ifdef GCD_CLIENT_TIMEOUT_EN
    task automatic test_timeout;
        do_reset;
        bus.req_rdy = 1;
        send(16'h0010, 16'h0008, 16'h0008);
        tick;
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (k == 15) begin
                vectors++;
                if (timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_early got %b want 0", timeout); end
            end
        end
        vectors++;
        if ({timeout, err} !== 2'b11) begin miscompares++; $display("FAIL timeout_hit got timeout=%b err=%b want 1 1", timeout, err); end
    endtask
`endif

    task automatic test_random;
        logic [31:0] pend[$];
        logic [15:0] exp_q[$];
        logic [15:0] gq[$];
        logic [47:0] cur;
        logic [15:0] g, a, b, e, r;
        logic [31:0] p;
        int m_sent, m_pass, m_fail, accepted, generated;
        bit m_err, have, sf, rf, pf, exp_srdy;
        m_sent = 0; m_pass = 0; m_fail = 0; accepted = 0; generated = 0;
        m_err = 0; have = 0; cur = '0;
        do_reset;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (accepted == 40 && exp_q.size() == 0 && pend.size() == 0) break;
            vectors++;
            if (bus.req_val !== (pend.size() != 0)) begin
                miscompares++; $display("FAIL rnd_req_val cyc%0d got %b want %b", cyc, bus.req_val, pend.size() != 0);
            end
            if (pend.size() != 0) begin
                vectors++;
                if (bus.req_msg !== pend[0]) begin
                    miscompares++; $display("FAIL rnd_req_msg cyc%0d got %h want %h", cyc, bus.req_msg, pend[0]);
                end
            end
            vectors++;
            if ({num_sent, num_pass, num_fail, err, idle} !==
                {CW'(m_sent), CW'(m_pass), CW'(m_fail), m_err, (pend.size() == 0 && exp_q.size() == 0)}) begin
                miscompares++;
                $display("FAIL rnd_status cyc%0d got s/p/f=%0d/%0d/%0d err=%b idle=%b want %0d/%0d/%0d %b %b",
                         cyc, num_sent, num_pass, num_fail, err, idle, m_sent, m_pass, m_fail, m_err,
                         pend.size() == 0 && exp_q.size() == 0);
            end
            if (!have && generated < 40) begin
                g = 16'($urandom_range(1, 50));
                a = g * 16'($urandom_range(1, 300));
                b = g * 16'($urandom_range(1, 300));
                e = gcd16(a, b);
                if ($urandom_range(0, 4) == 0) e = e + 16'd1;
                cur = {a, b, e}; have = 1; generated++;
            end
            bus.src_val  = have && ($urandom_range(0, 3) != 0);
            bus.src_msg  = cur;
            bus.req_rdy  = ($urandom_range(0, 2) != 0);
            bus.resp_val = (gq.size() != 0) && ($urandom_range(0, 2) != 0);
            bus.resp_msg = (gq.size() != 0) ? gq[0] : 16'h0;
            #1;
            exp_srdy = (pend.size() == 0 || bus.req_rdy) && (exp_q.size() < 4);
            vectors++;
            if ({bus.src_rdy, bus.resp_rdy} !== {exp_srdy, (gq.size() != 0)}) begin
                miscompares++;
                $display("FAIL rnd_rdy cyc%0d got src_rdy=%b resp_rdy=%b want %b %b", cyc, bus.src_rdy, bus.resp_rdy, exp_srdy, gq.size() != 0);
            end
            sf = bus.src_val && bus.src_rdy;
            rf = bus.req_val && bus.req_rdy;
            pf = bus.resp_val && bus.resp_rdy;
            if (pf && gq.size() != 0 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                r = gq.pop_front();
                if (r == e) begin if (m_pass < CMAX) m_pass++; end
                else begin if (m_fail < CMAX) m_fail++; m_err = 1; end
            end
            if (rf && pend.size() != 0) begin
                p = pend.pop_front();
                gq.push_back(gcd16(p[31:16], p[15:0]));
                if (m_sent < CMAX) m_sent++;
            end
            if (sf) begin
                pend.push_back(cur[47:16]);
                exp_q.push_back(cur[15:0]);
                have = 0; accepted++;
            end
            tick;
        end
        vectors++;
        if (accepted != 40 || exp_q.size() != 0) begin
            miscompares++; $display("FAIL rnd_drain got accepted=%0d open=%0d want 40 0", accepted, exp_q.size());
        end
        bus.src_val = 0; bus.resp_val = 0;
    endtask

    initial begin
        bus.src_val = 0; bus.src_msg = '0; bus.req_rdy = 0;
        bus.resp_val = 0; bus.resp_msg = '0;
        @(negedge clk);
        test_reset;
        test_single_pass;
        test_mismatch;
        test_full_fifo;
        test_backpressure;
        test_streaming;
        test_async_reset;
`ifdef GCD_CLIENT_TIMEOUT_EN
        test_timeout;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
